// File: rtl/rvlab_tap_pkg.sv
// Shared TAP types and constants: IR codes, IDCODE value, DTM register layouts, TAP state encoding.
// No logic; latency and backpressure are not applicable.
package rvlab_tap_pkg;

  localparam logic [4:0] IrIdcode    = 5'h01;
  localparam logic [4:0] IrDtmcsr    = 5'h10;
  localparam logic [4:0] IrDmiAccess = 5'h11;
  localparam logic [4:0] IrBypass    = 5'h1F;

  // Bit 0 must be 1 for a valid IEEE 1149.1 IDCODE.
  localparam logic [31:0] IdcodeValue = 32'h1001_A0B3;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef enum logic [3:0] {
    TapTlr, TapIdle,
    TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr, TapUpdDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpdIr
  } tap_state_e;

endpackage

// File: rtl/rvlab_jtag_sync.sv
// 2-flop synchronisers for TCK/TMS/TDI/TRST plus single-cycle TCK rise/fall strobes.
// Latency: pin edge to strobe 3 clk_i cycles; no backpressure.
module rvlab_jtag_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_tck,
  input  logic i_tms,
  input  logic i_tdi,
  input  logic i_trst_n,
  output logic o_tck_rise,
  output logic o_tck_fall,
  output logic o_tms,
  output logic o_tdi,
  output logic o_trst_n
);

  // Bit order {trst_n, tdi, tms, tck}; trst_n resets to its inactive level.
  localparam logic [3:0] SyncRst = 4'b1000;

  logic [3:0] r_meta;
  logic [3:0] r_sync;
  logic       r_tck_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta  <= SyncRst;
      r_sync  <= SyncRst;
      r_tck_d <= 1'b0;
    end else begin
      r_meta  <= {i_trst_n, i_tdi, i_tms, i_tck};
      r_sync  <= r_meta;
      r_tck_d <= r_sync[0];
    end
  end

  assign o_tck_rise = r_sync[0] & ~r_tck_d;
  assign o_tck_fall = ~r_sync[0] & r_tck_d;
  assign o_tms      = r_sync[1];
  assign o_tdi      = r_sync[2];
  assign o_trst_n   = r_sync[3];

endmodule

// File: rtl/rvlab_jtag_tap.sv
// Oversampled JTAG TAP (IR, IDCODE, BYPASS, DTMCSR, DMIACCESS); RVLAB_TAP_TRST_EN enables jtag_trst_ni.
// Latency: state/shift visible 1 cycle after tck_rise, TDO 1 cycle after tck_fall; no backpressure.
module rvlab_jtag_tap
  import rvlab_tap_pkg::*;
#(
  parameter int          IrWidth   = 5,
  parameter int          DmiWidth  = 41,
  parameter logic [31:0] IdcodeVal = IdcodeValue
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                jtag_tck_i,
  input  logic                jtag_tms_i,
  input  logic                jtag_tdi_i,
  input  logic                jtag_trst_ni,
  output logic                jtag_tdo_o,
  output logic                jtag_tdo_oe_o,
  output logic [IrWidth-1:0]  ir_o,
  output logic                tlr_o,
  input  logic [31:0]         dtmcs_rdata_i,
  output logic [31:0]         dtmcs_wdata_o,
  output logic                dtmcs_we_o,
  input  logic [DmiWidth-1:0] dmi_rdata_i,
  output logic [DmiWidth-1:0] dmi_req_o,
  output logic                dmi_req_valid_o
);

  localparam int                 DrIdxW = $clog2(DmiWidth);
  localparam logic [IrWidth-1:0] LIrIdc = IrWidth'(IrIdcode);
  localparam logic [IrWidth-1:0] LIrDtm = IrWidth'(IrDtmcsr);
  localparam logic [IrWidth-1:0] LIrDmi = IrWidth'(IrDmiAccess);

  logic w_tck_rise, w_tck_fall, w_tms, w_tdi, w_trst_n, w_soft_rst;

  rvlab_jtag_sync u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_tck      (jtag_tck_i),
    .i_tms      (jtag_tms_i),
    .i_tdi      (jtag_tdi_i),
    .i_trst_n   (jtag_trst_ni),
    .o_tck_rise (w_tck_rise),
    .o_tck_fall (w_tck_fall),
    .o_tms      (w_tms),
    .o_tdi      (w_tdi),
    .o_trst_n   (w_trst_n)
  );

`ifdef RVLAB_TAP_TRST_EN
  assign w_soft_rst = ~w_trst_n;
`else
  logic w_unused_trst;
  assign w_unused_trst = w_trst_n;
  assign w_soft_rst    = 1'b0;
`endif

  tap_state_e          r_state, w_state_next;
  logic [IrWidth-1:0]  r_ir, r_ir_sr;
  logic [DmiWidth-1:0] r_dr, w_dr_cap, w_dr_shift;
  logic [DrIdxW-1:0]   w_dr_msb;
  logic                r_tdo;
  logic [31:0]         r_dtmcs_wdata;
  logic                r_dtmcs_we;
  logic [DmiWidth-1:0] r_dmi_req;
  logic                r_dmi_req_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= TapTlr;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_soft_rst) begin
      w_state_next = TapTlr;
    end else if (w_tck_rise) begin
      case (r_state)
        TapTlr:   w_state_next = w_tms ? TapTlr   : TapIdle;
        TapIdle:  w_state_next = w_tms ? TapSelDr : TapIdle;
        TapSelDr: w_state_next = w_tms ? TapSelIr : TapCapDr;
        TapCapDr: w_state_next = w_tms ? TapEx1Dr : TapShDr;
        TapShDr:  w_state_next = w_tms ? TapEx1Dr : TapShDr;
        TapEx1Dr: w_state_next = w_tms ? TapUpdDr : TapPauDr;
        TapPauDr: w_state_next = w_tms ? TapEx2Dr : TapPauDr;
        TapEx2Dr: w_state_next = w_tms ? TapUpdDr : TapShDr;
        TapUpdDr: w_state_next = w_tms ? TapSelDr : TapIdle;
        TapSelIr: w_state_next = w_tms ? TapTlr   : TapCapIr;
        TapCapIr: w_state_next = w_tms ? TapEx1Ir : TapShIr;
        TapShIr:  w_state_next = w_tms ? TapEx1Ir : TapShIr;
        TapEx1Ir: w_state_next = w_tms ? TapUpdIr : TapPauIr;
        TapPauIr: w_state_next = w_tms ? TapEx2Ir : TapPauIr;
        TapEx2Ir: w_state_next = w_tms ? TapUpdIr : TapShIr;
        TapUpdIr: w_state_next = w_tms ? TapSelDr : TapIdle;
        default:  w_state_next = TapTlr;
      endcase
    end
  end

  // Active DR length and capture source follow IR; unknown codes act as BYPASS.
  always_comb begin
    w_dr_msb = '0;
    w_dr_cap = '0;
    case (r_ir)
      LIrIdc: begin w_dr_msb = DrIdxW'(31);           w_dr_cap = DmiWidth'(IdcodeVal);     end
      LIrDtm: begin w_dr_msb = DrIdxW'(31);           w_dr_cap = DmiWidth'(dtmcs_rdata_i); end
      LIrDmi: begin w_dr_msb = DrIdxW'(DmiWidth - 1); w_dr_cap = dmi_rdata_i;              end
      default: ;
    endcase
    w_dr_shift           = r_dr >> 1;
    w_dr_shift[w_dr_msb] = w_tdi;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ir          <= LIrIdc;
      r_ir_sr       <= '0;
      r_dr          <= '0;
      r_tdo         <= 1'b0;
      r_dtmcs_wdata <= '0;
      r_dtmcs_we    <= 1'b0;
      r_dmi_req     <= '0;
      r_dmi_req_vld <= 1'b0;
    end else begin
      r_dtmcs_we    <= 1'b0;
      r_dmi_req_vld <= 1'b0;
      if (w_soft_rst) begin
        r_ir    <= LIrIdc;
        r_ir_sr <= '0;
        r_dr    <= '0;
      end else begin
        if (w_tck_fall) begin
          if (r_state == TapShDr)      r_tdo <= r_dr[0];
          else if (r_state == TapShIr) r_tdo <= r_ir_sr[0];
        end
        if (w_tck_rise) begin
          case (r_state)
            TapCapIr: r_ir_sr <= IrWidth'(1);
            TapShIr:  r_ir_sr <= {w_tdi, r_ir_sr[IrWidth-1:1]};
            TapCapDr: r_dr    <= w_dr_cap;
            TapShDr:  r_dr    <= w_dr_shift;
            default: ;
          endcase
          if (w_state_next == TapTlr)         r_ir <= LIrIdc;
          else if (w_state_next == TapUpdIr)  r_ir <= r_ir_sr;
          if (w_state_next == TapUpdDr) begin
            if (r_ir == LIrDtm) begin
              r_dtmcs_wdata <= r_dr[31:0];
              r_dtmcs_we    <= 1'b1;
            end else if (r_ir == LIrDmi) begin
              r_dmi_req     <= r_dr;
              r_dmi_req_vld <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign jtag_tdo_o      = r_tdo;
  assign jtag_tdo_oe_o   = (r_state == TapShDr) || (r_state == TapShIr);
  assign ir_o            = r_ir;
  assign tlr_o           = (r_state == TapTlr);
  assign dtmcs_wdata_o   = r_dtmcs_wdata;
  assign dtmcs_we_o      = r_dtmcs_we;
  assign dmi_req_o       = r_dmi_req;
  assign dmi_req_valid_o = r_dmi_req_vld;

endmodule

// File: tb/tb_rvlab_jtag_tap.sv
// Directed JTAG scans against a bench-side TAP model, checked every settled cycle.
`timescale 1ns/1ps
module tb_rvlab_jtag_tap;
  import rvlab_tap_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        jtag_tck_i = 1'b0, jtag_tms_i = 1'b1, jtag_tdi_i = 1'b0, jtag_trst_ni = 1'b1;
  logic        jtag_tdo_o, jtag_tdo_oe_o, tlr_o;
  logic [4:0]  ir_o;
  logic [31:0] dtmcs_rdata_i = 32'h0, dtmcs_wdata_o;
  logic        dtmcs_we_o;
  logic [40:0] dmi_rdata_i = 41'h0, dmi_req_o;
  logic        dmi_req_valid_o;

  rvlab_jtag_tap dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .jtag_tck_i(jtag_tck_i), .jtag_tms_i(jtag_tms_i), .jtag_tdi_i(jtag_tdi_i),
    .jtag_trst_ni(jtag_trst_ni), .jtag_tdo_o(jtag_tdo_o), .jtag_tdo_oe_o(jtag_tdo_oe_o),
    .ir_o(ir_o), .tlr_o(tlr_o),
    .dtmcs_rdata_i(dtmcs_rdata_i), .dtmcs_wdata_o(dtmcs_wdata_o), .dtmcs_we_o(dtmcs_we_o),
    .dmi_rdata_i(dmi_rdata_i), .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // State ids: 0 TLR, 1 RTI, 2-8 SelDR..UpdDR, 9-15 SelIR..UpdIR
  localparam int S_TLR = 0, S_CDR = 3, S_SHDR = 4, S_UDR = 8, S_CIR = 10, S_SHIR = 11, S_UIR = 15;
  int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int          m_st;
  logic [4:0]  m_ir, m_irsr;
  logic [63:0] m_dr;
  logic        m_tdo;
  int          exp_dtmcs_n = 0, act_dtmcs_n = 0, exp_dmi_n = 0, act_dmi_n = 0;
  logic [31:0] exp_dtmcs_dat = '0;
  logic [40:0] exp_dmi_dat = '0;
  bit          settled = 1'b0;

  function automatic int dr_len();
    case (m_ir)
      5'h01, 5'h10: return 32;
      5'h11:        return 41;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [63:0] cap_val();
    case (m_ir)
      5'h01:   return {32'h0, IdcodeValue};
      5'h10:   return {32'h0, dtmcs_rdata_i};
      5'h11:   return {23'h0, dmi_rdata_i};
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_TLR; m_ir = 5'h01; m_irsr = '0; m_dr = '0; m_tdo = 1'b0;
  endtask

  task automatic model_rise(input bit tms, input bit tdi);
    int nxt;
    nxt = tms ? nx1[m_st] : nx0[m_st];
    if (m_st == S_CDR) m_dr = cap_val();
    else if (m_st == S_SHDR) begin
      m_dr = m_dr >> 1;
      m_dr[dr_len()-1] = tdi;
    end else if (m_st == S_CIR) m_irsr = 5'h01;
    else if (m_st == S_SHIR) m_irsr = {tdi, m_irsr[4:1]};
    if (nxt == S_UIR) m_ir = m_irsr;
    if (nxt == S_TLR) m_ir = 5'h01;
    if (nxt == S_UDR) begin
      if (m_ir == 5'h10) begin exp_dtmcs_n++; exp_dtmcs_dat = m_dr[31:0]; end
      else if (m_ir == 5'h11) begin exp_dmi_n++; exp_dmi_dat = m_dr[40:0]; end
    end
    m_st = nxt;
  endtask

  task automatic model_fall();
    if (m_st == S_SHDR) m_tdo = m_dr[0];
    else if (m_st == S_SHIR) m_tdo = m_irsr[0];
  endtask

  always @(negedge clk_i) begin
    if (settled) begin
      chk("tlr_o", {63'h0, tlr_o}, {63'h0, m_st == S_TLR});
      chk("ir_o", {59'h0, ir_o}, {59'h0, m_ir});
      chk("tdo_oe", {63'h0, jtag_tdo_oe_o}, {63'h0, (m_st == S_SHDR) || (m_st == S_SHIR)});
      chk("tdo", {63'h0, jtag_tdo_o}, {63'h0, m_tdo});
    end
    if (dtmcs_we_o) begin
      act_dtmcs_n++;
      chk("dtmcs_wdata", {32'h0, dtmcs_wdata_o}, {32'h0, exp_dtmcs_dat});
    end
    if (dmi_req_valid_o) begin
      act_dmi_n++;
      chk("dmi_req", {23'h0, dmi_req_o}, {23'h0, exp_dmi_dat});
    end
  end

  task automatic settle();
    repeat (5) @(posedge clk_i);
    #1 settled = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic tck_cycle(input bit tms, input bit tdi, output bit tdo_s);
    jtag_tms_i = tms; jtag_tdi_i = tdi;
    @(posedge clk_i); #1;
    tdo_s = jtag_tdo_o;
    settled = 1'b0; jtag_tck_i = 1'b1; model_rise(tms, tdi);
    settle();
    settled = 1'b0; jtag_tck_i = 1'b0; model_fall();
    settle();
  endtask

  task automatic tick(input bit tms);
    bit d;
    tck_cycle(tms, 1'b0, d);
  endtask

  task automatic shift_ir(input logic [4:0] ir);
    bit d;
    tick(1); tick(1); tick(0); tick(0);
    for (int i = 0; i < 5; i++) tck_cycle(i == 4, ir[i], d);
    tick(1); tick(0);
  endtask

  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    bit b;
    dout = '0;
    tick(1); tick(0); tick(0);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tick(1); tick(0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] dout;
    logic [40:0] req;
    dmi_req_t    rq;
    int          snap_dtm, snap_dmi;
    bit          d;

    model_reset();
    repeat (3) @(posedge clk_i); #1;
    chk("rst_tlr", {63'h0, tlr_o}, 64'h1);
    chk("rst_ir", {59'h0, ir_o}, 64'h01);
    chk("rst_tdo", {63'h0, jtag_tdo_o}, 64'h0);
    chk("rst_oe", {63'h0, jtag_tdo_oe_o}, 64'h0);
    chk("rst_we", {63'h0, dtmcs_we_o}, 64'h0);
    chk("rst_vld", {63'h0, dmi_req_valid_o}, 64'h0);
    chk("rst_wdata", {32'h0, dtmcs_wdata_o}, 64'h0);
    chk("rst_req", {23'h0, dmi_req_o}, 64'h0);
    rst_ni = 1'b1;
    settle();
    repeat (5) tick(1);
    tick(0);

    // IDCODE read
    shift_ir(5'h01);
    shift_dr(64'h0, 32, dout);
    chk("idcode", dout, {32'h0, IdcodeValue});

    // BYPASS: 8'hA5 plus one trailing bit comes back delayed by one
    shift_ir(5'h1F);
    chk("ir_bypass", {59'h0, ir_o}, 64'h1F);
    shift_dr(64'h0A5, 9, dout);
    chk("bypass", dout, 64'h14A);

    // DTMCSR capture and update
    dtmcs_rdata_i = 32'h0000_0071;
    shift_ir(5'h10);
    shift_dr(64'h0001_0000, 32, dout);
    chk("dtmcs_cap", dout, 64'h71);
    chk("dtmcs_pulses", act_dtmcs_n, 1);
    chk("dtmcs_wdata_hold", {32'h0, dtmcs_wdata_o}, 64'h0001_0000);

    // DMI request {addr 0x10, data 1, op 2}: addr lands at bit 34
    dmi_rdata_i = 41'h155_AA55_C33C;
    rq = '{addr: 7'h10, data: 32'h0000_0001, op: 2'b10};
    req = rq;
    shift_ir(5'h11);
    shift_dr({23'h0, req}, 41, dout);
    chk("dmi_cap1", dout, {23'h0, 41'h155_AA55_C33C});
    chk("dmi_pulses1", act_dmi_n, 1);
    chk("dmi_req_hold", {23'h0, dmi_req_o}, 64'h40_0000_0006);
    dmi_rdata_i = 41'h0F0_0F0F_1234;
    shift_dr(64'h0, 41, dout);
    chk("dmi_cap2", dout, {23'h0, 41'h0F0_0F0F_1234});
    chk("dmi_pulses2", act_dmi_n, 2);

    // TMS reset from mid Shift-DR (BYPASS so the Update-DR pass is a no-op)
    shift_ir(5'h1F);
    snap_dtm = act_dtmcs_n; snap_dmi = act_dmi_n;
    tick(1); tick(0); tick(0);
    repeat (3) tck_cycle(0, 1, d);
    repeat (5) tick(1);
    chk("tms_rst_tlr", {63'h0, tlr_o}, 64'h1);
    chk("tms_rst_ir", {59'h0, ir_o}, 64'h01);
    chk("tms_rst_nostrobe", act_dtmcs_n + act_dmi_n, snap_dtm + snap_dmi);
    tick(0);

    // rst_ni mid Shift-IR
    tick(1); tick(1); tick(0); tick(0);
    tck_cycle(0, 1, d); tck_cycle(0, 0, d);
    chk("shir_oe", {63'h0, jtag_tdo_oe_o}, 64'h1);
    settled = 1'b0; rst_ni = 1'b0; model_reset();
    #1;
    chk("arst_tlr", {63'h0, tlr_o}, 64'h1);
    chk("arst_oe", {63'h0, jtag_tdo_oe_o}, 64'h0);
    chk("arst_ir", {59'h0, ir_o}, 64'h01);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    settle();
    tick(0);

    // TRST mid Shift-IR
    tick(1); tick(1); tick(0); tick(0);
    tck_cycle(0, 1, d);
    settled = 1'b0; jtag_trst_ni = 1'b0;
`ifdef RVLAB_TAP_TRST_EN
    m_st = S_TLR; m_ir = 5'h01; m_irsr = '0; m_dr = '0;
`endif
    repeat (5) @(posedge clk_i); #1;
`ifdef RVLAB_TAP_TRST_EN
    chk("trst_tlr", {63'h0, tlr_o}, 64'h1);
    chk("trst_oe", {63'h0, jtag_tdo_oe_o}, 64'h0);
    chk("trst_ir", {59'h0, ir_o}, 64'h01);
`else
    chk("trst_ign_tlr", {63'h0, tlr_o}, 64'h0);
    chk("trst_ign_oe", {63'h0, jtag_tdo_oe_o}, 64'h1);
`endif
    jtag_trst_ni = 1'b1;
    settle();
    repeat (5) tick(1);
    tick(0);

    chk("dtmcs_total", act_dtmcs_n, exp_dtmcs_n);
    chk("dmi_total", act_dmi_n, exp_dmi_n);
    chk("dtmcs_total_lit", act_dtmcs_n, 1);
    chk("dmi_total_lit", act_dmi_n, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
